// File: rtl/core_addr_router.sv
// rtl/core_addr_router.sv - registered bus-request router with slice strobes, spike walk, weight select and picture counter
module core_addr_router #(
    parameter int NUM_OF_SLICE  = 4,
    parameter int DONE_PIC_ADDR = 448,
    parameter int PIC_CNT_W     = 8,
    localparam int SEL_W        = (NUM_OF_SLICE > 1) ? $clog2(NUM_OF_SLICE) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [SEL_W+8:0]        addr_i,
    input  logic                    we_i,
    output logic [NUM_OF_SLICE-1:0] slice_o,
    output logic                    send_spike_o,
    output logic                    spike_done_o,
    output logic                    choose_weight_o,
    output logic                    done_pic_o,
    output logic [PIC_CNT_W-1:0]    pic_cnt_o,
    output logic                    err_o
);

    localparam logic       IDLE = 1'b0;
    localparam logic       WALK = 1'b1;
    localparam logic [8:0] DONE_OFF = 9'(DONE_PIC_ADDR);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OF_SLICE - 1);
    localparam logic [SEL_W:0]   NUM_W = (SEL_W + 1)'(NUM_OF_SLICE);

    logic             state;
    logic [SEL_W-1:0] walk_idx;
    logic [8:0]       off;
    logic [SEL_W-1:0] sel;
    logic             accept;

    assign off         = addr_i[8:0];
    assign sel         = addr_i[SEL_W+8:9];
    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            walk_idx        <= '0;
            slice_o         <= '0;
            send_spike_o    <= 1'b0;
            spike_done_o    <= 1'b0;
            choose_weight_o <= 1'b0;
            done_pic_o      <= 1'b0;
            pic_cnt_o       <= '0;
            err_o           <= 1'b0;
        end else begin
            slice_o      <= '0;
            send_spike_o <= 1'b0;
            spike_done_o <= 1'b0;
            done_pic_o   <= 1'b0;
            err_o        <= 1'b0;

            if (state == WALK) begin
                // The cycle that showed spike_done is the last strobe of the walk.
                if (spike_done_o) begin
                    state <= IDLE;
                end else begin
                    slice_o      <= NUM_OF_SLICE'(1) << walk_idx;
                    send_spike_o <= 1'b1;
                    spike_done_o <= (walk_idx == LAST_IDX);
                    walk_idx     <= walk_idx + SEL_W'(1);
                end
            end else if (accept) begin
                if (off == DONE_OFF) begin
                    done_pic_o <= 1'b1;
                    slice_o    <= {NUM_OF_SLICE{1'b1}};
                    pic_cnt_o  <= pic_cnt_o + PIC_CNT_W'(1);
                end else if (off[8:6] == 3'b111) begin
                    choose_weight_o <= off[4];
                end else if (we_i || off[8]) begin
                    if ({1'b0, sel} < NUM_W) begin
                        slice_o <= NUM_OF_SLICE'(1) << sel;
                    end else begin
                        err_o <= 1'b1;
                    end
                end else begin
                    // Slice 0 is strobed on entry; the walk continues from index 1.
                    state        <= WALK;
                    slice_o      <= NUM_OF_SLICE'(1);
                    send_spike_o <= 1'b1;
                    spike_done_o <= (NUM_OF_SLICE == 1);
                    walk_idx     <= SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_core_addr_router.sv
// tb/tb_core_addr_router.sv - randomized model-checked bench for core_addr_router
module tb_core_addr_router;

    localparam int N  = 4;
    localparam int PW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, we;
    logic [10:0] addr;
    logic        ready, spike, sdone, cw, done, err;
    logic [3:0]  slice;
    logic [PW-1:0] pic;

    logic        valid3, we3;
    logic [10:0] addr3;
    logic        ready3, spike3, sdone3, cw3, done3, err3;
    logic [2:0]  slice3;
    logic [7:0]  pic3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_addr_router #(.NUM_OF_SLICE(N), .DONE_PIC_ADDR(448), .PIC_CNT_W(PW)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
        .addr_i(addr), .we_i(we), .slice_o(slice), .send_spike_o(spike),
        .spike_done_o(sdone), .choose_weight_o(cw), .done_pic_o(done),
        .pic_cnt_o(pic), .err_o(err)
    );

    core_addr_router #(.NUM_OF_SLICE(3), .DONE_PIC_ADDR(448), .PIC_CNT_W(8)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid3), .req_ready_o(ready3),
        .addr_i(addr3), .we_i(we3), .slice_o(slice3), .send_spike_o(spike3),
        .spike_done_o(sdone3), .choose_weight_o(cw3), .done_pic_o(done3),
        .pic_cnt_o(pic3), .err_o(err3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs for the cycle after each edge.
    logic [3:0] exp_slice = '0;
    logic exp_spike = 0, exp_sdone = 0, exp_done = 0, exp_err = 0, exp_cw = 0, exp_ready = 1;
    int   m_pic = 0, m_walk = N, m_off, m_sel;
    bit   m_on = 0;
    logic cur_ready;

    always @(posedge clk) begin
        cur_ready = exp_ready;
        m_off = int'(addr[8:0]);
        m_sel = int'(addr[10:9]);
        exp_slice = '0; exp_spike = 0; exp_sdone = 0; exp_done = 0; exp_err = 0;
        if (rst) begin
            exp_cw = 0; m_pic = 0; m_walk = N; m_on = 1;
        end else if (m_walk < N) begin
            exp_slice = 4'(1 << m_walk);
            exp_spike = 1;
            exp_sdone = (m_walk == N - 1);
            m_walk++;
        end else if (valid && cur_ready) begin
            if (m_off == 448) begin
                exp_done = 1;
                exp_slice = 4'hF;
                m_pic = (m_pic + 1) % (1 << PW);
            end else if (m_off >= 448) begin
                exp_cw = ((m_off >> 4) & 1) != 0;
            end else if (we || m_off >= 256) begin
                if (m_sel < N) exp_slice = 4'(1 << m_sel);
                else exp_err = 1;
            end else begin
                exp_slice = 4'd1;
                exp_spike = 1;
                exp_sdone = (N == 1);
                m_walk = 1;
            end
        end
        exp_ready = !exp_spike;
    end

    always @(negedge clk) begin
        if (m_on)
            chk("cycle {ready,slice,spike,sdone,cw,done,pic,err}",
                {20'd0, ready, slice, spike, sdone, cw, done, pic, err},
                {20'd0, exp_ready, exp_slice, exp_spike, exp_sdone, exp_cw, exp_done, PW'(m_pic), exp_err});
    end

    initial begin
        logic [1:0] pic_seq [5];
        pic_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1; valid = 0; addr = '0; we = 0;
        valid3 = 0; addr3 = '0; we3 = 0;
        @(negedge clk); @(negedge clk);
        rst = 0;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset slice", 32'(slice), 32'd0);
        chk("reset pic", 32'(pic), 32'd0);

        valid = 1; addr = 11'h405; we = 1;
        @(negedge clk); valid = 0;
        chk("write slice", 32'(slice), 32'b0100);
        chk("write ready", 32'(ready), 32'd1);
        @(negedge clk);
        chk("write slice clear", 32'(slice), 32'd0);

        valid = 1; addr = 11'h010; we = 0;
        @(negedge clk);
        chk("walk T1 slice", 32'(slice), 32'b0001);
        chk("walk T1 ready", 32'(ready), 32'd0);
        addr = 11'h405; we = 1;
        @(negedge clk); chk("walk T2 slice", 32'(slice), 32'b0010);
        @(negedge clk); chk("walk T3 sdone", 32'(sdone), 32'd0);
        @(negedge clk);
        chk("walk T4 slice", 32'(slice), 32'b1000);
        chk("walk T4 spike", 32'(spike), 32'd1);
        chk("walk T4 sdone", 32'(sdone), 32'd1);
        @(negedge clk);
        chk("walk T5 ready", 32'(ready), 32'd1);
        chk("walk T5 spike", 32'(spike), 32'd0);
        @(negedge clk); valid = 0;
        chk("held write accepted", 32'(slice), 32'b0100);

        valid = 1; addr = 11'h5C0; we = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_pic", 32'(done), 32'd1);
            chk("done_pic slice", 32'(slice), 32'hF);
            chk("pic_cnt", 32'(pic), 32'(pic_seq[i]));
        end
        valid = 0;
        @(negedge clk); chk("done_pic clear", 32'(done), 32'd0);

        valid = 1; addr = 11'h1D0;
        @(negedge clk); valid = 0;
        chk("cw set", 32'(cw), 32'd1);
        chk("cw slice", 32'(slice), 32'd0);
        repeat (10) @(negedge clk);
        chk("cw held", 32'(cw), 32'd1);
        valid = 1; addr = 11'h1C1;
        @(negedge clk); valid = 0;
        chk("cw clear", 32'(cw), 32'd0);

        valid3 = 1; addr3 = 11'h600; we3 = 1;
        @(negedge clk); valid3 = 0;
        chk("n3 err", 32'(err3), 32'd1);
        chk("n3 slice", 32'(slice3), 32'd0);
        @(negedge clk);
        chk("n3 err clear", 32'(err3), 32'd0);

        valid = 1; addr = 11'h1D0; we = 0;
        @(negedge clk);
        addr = 11'h010;
        @(negedge clk); valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0;
        chk("abort slice", 32'(slice), 32'd0);
        chk("abort spike", 32'(spike), 32'd0);
        chk("abort cw", 32'(cw), 32'd0);
        chk("abort pic", 32'(pic), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("abort no sdone", 32'(sdone), 32'd0);
        end

        repeat (3000) begin
            rst   = ($urandom_range(0, 299) == 0);
            valid = $urandom_range(0, 1) == 1;
            we    = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: addr = 11'($urandom);
                1: addr = {2'($urandom), 9'd448};
                2: addr = {2'($urandom), 3'b111, 6'($urandom)};
                default: addr = {2'($urandom), 1'b0, 8'($urandom)};
            endcase
            @(negedge clk);
        end
        rst = 0; valid = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_addr_router.md
Name: core_addr_router

Overview:
- Registered, multi-slice successor to the single-cycle core address decoder. Accepts one bus request per valid/ready handshake, splits the address into slice-select and 9-bit local offset, and issues one-cycle slice strobes.
- Adds three things the combinational decoder lacks: a sequential spike-broadcast walk across slices, a sticky choose-weight register, and a done-picture counter.
- Sits between the core bus master and the NUM_OF_SLICE neuron slices.

Parameters:
- NUM_OF_SLICE, 4, number of slices; must be >= 1. Localparam SEL_W = max(1, clog2(NUM_OF_SLICE)).
- DONE_PIC_ADDR, 448, local offset (9-bit) that triggers the done-picture broadcast.
- PIC_CNT_W, 8, width of the done-picture counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  router can accept a request.
- addr_i  in  SEL_W+9  [SEL_W+8:9] = slice index, [8:0] = local offset.
- we_i  in  1  write request.
- slice_o  out  NUM_OF_SLICE  per-slice strobe, registered.
- send_spike_o  out  1  spike-broadcast strobe (walk active).
- spike_done_o  out  1  pulse on the last walk cycle.
- choose_weight_o  out  1  sticky weight-bank select.
- done_pic_o  out  1  done-picture pulse.
- pic_cnt_o  out  PIC_CNT_W  count of done-picture events.
- err_o  out  1  pulse when the slice index is out of range.

Behaviour:
- Accept condition: req_valid_i && req_ready_o at a rising edge (cycle T). All responses appear registered from T+1.
- Reset (rst_i=1 at an edge) gives, on the next cycle:
  - all outputs 0, except req_ready_o=1;
  - state=IDLE, walk index=0, pic_cnt_o=0, choose_weight_o=0.
  - Reset mid-walk aborts the walk; no spike_done_o pulse.
- States: IDLE and WALK. req_ready_o = (state==IDLE).
- Decode of an accepted request, priority top-down (off = local offset, sel = slice index):
  1. off==DONE_PIC_ADDR → at T+1: done_pic_o=1, slice_o=all ones, pic_cnt_o increments (wraps 2^PIC_CNT_W-1 → 0). sel and we_i are ignored.
  2. off[8:6]==3'b111 (and not DONE_PIC_ADDR) → choose_weight_o <= off[4] at T+1. Holds until the next such access or reset. slice_o=0.
  3. we_i || off[8] → if sel < NUM_OF_SLICE: slice_o one-hot at bit sel for T+1 only. Otherwise slice_o=0 and err_o=1 for T+1.
  4. Otherwise (read, off[8]==0) → enter WALK.
- WALK:
  - Cycles T+1..T+NUM_OF_SLICE: slice_o one-hot at bit k (k = 0..NUM_OF_SLICE-1) and send_spike_o=1.
  - spike_done_o=1 only at T+NUM_OF_SLICE.
  - Return to IDLE at T+NUM_OF_SLICE+1.
  - req_ready_o=0 for T+1..T+NUM_OF_SLICE; requests presented then are not accepted and must be held by the master.
  - NUM_OF_SLICE=1 gives a one-cycle walk with send_spike_o and spike_done_o together.
- Single-cycle pulses (done_pic_o, err_o, slice_o from cases 1/3) return to 0 at T+2 unless a new request was accepted at T+1. Back-to-back accepts in IDLE give strobes on consecutive cycles.
- No request accepted → slice_o=0, done_pic_o=0, send_spike_o=0, err_o=0. choose_weight_o and pic_cnt_o hold.
- Only one decode case applies per request; outputs from different cases never overlap in the same cycle.

Test Plan:
- Reset, then NUM_OF_SLICE=4, write addr=0x405 (sel 2, off 0x005) → T+1: slice_o=4'b0100, others 0, req_ready_o=1; T+2: slice_o=0.
- Read addr=0x010 (off[8]=0) → slice_o=0001, 0010, 0100, 1000 on T+1..T+4; send_spike_o=1 throughout; spike_done_o only at T+4; req_ready_o=0 T+1..T+4, 1 at T+5; a valid held during the walk is accepted at T+5.
- addr=0x5C0 (off 448) → done_pic_o=1, slice_o=4'b1111 at T+1, pic_cnt_o 0→1. With PIC_CNT_W=2, four more events give 1→2→3→0→1.
- addr=0x1D0 → choose_weight_o=1 from T+1 and held through 10 idle cycles; addr=0x1C1 → 0. slice_o stays 0 for both.
- Parameter NUM_OF_SLICE=3, write to sel 3 (addr=0x600) → err_o=1, slice_o=0 at T+1.
- Assert rst_i at walk cycle T+2 → next cycle: slice_o=0, send_spike_o=0, choose_weight_o=0, pic_cnt_o=0, req_ready_o=1; no spike_done_o.
